// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters that gate instruction
// issue on RAW hazards and on counter saturation, with same-cycle writeback bypass.
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int CNTW  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic        issue_uses_rs1,
  input  logic        issue_uses_rs2,
  input  logic        issue_RegWrite,
  input  logic [4:0]  issue_rd,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic        issue_ready,
  output logic [31:0] busy_mask,
  output logic [6:0]  outstanding,
  output logic        err_underflow
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic [CNTW-1:0] w_cnt      [32];
  logic [CNTW-1:0] w_cnt_next [32];
  logic            w_haz1;
  logic            w_haz2;
  logic            w_sat;
  logic            w_inc;
  logic            w_wb;
  logic            w_same_rd;
  logic            w_underflow;
  logic [6:0]      w_sum;
  logic [6:0]      r_outstanding;
  logic            r_err;

  // A pending write that retires this cycle is forwarded by the register file,
  // so a single outstanding write on the source is not a hazard.
  assign w_haz1 = issue_uses_rs1 && (issue_rs1 != 5'd0) && (w_cnt[issue_rs1] != '0) &&
                  !(wb_valid && (wb_rd == issue_rs1) && (w_cnt[issue_rs1] == CNT_ONE));
  assign w_haz2 = issue_uses_rs2 && (issue_rs2 != 5'd0) && (w_cnt[issue_rs2] != '0) &&
                  !(wb_valid && (wb_rd == issue_rs2) && (w_cnt[issue_rs2] == CNT_ONE));
  assign w_sat  = issue_RegWrite && (issue_rd != 5'd0) && (w_cnt[issue_rd] == CNT_MAX) &&
                  !(wb_valid && (wb_rd == issue_rd));

  assign issue_ready = !flush && !w_haz1 && !w_haz2 && !w_sat;

  assign w_inc       = issue_valid && issue_ready && issue_RegWrite && (issue_rd != 5'd0);
  assign w_wb        = wb_valid && (wb_rd != 5'd0);
  assign w_same_rd   = w_inc && w_wb && (issue_rd == wb_rd);
  assign w_underflow = w_wb && (w_cnt[wb_rd] == '0) && !flush;

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      w_cnt_next[i] = w_cnt[i];
      if (flush) begin
        w_cnt_next[i] = '0;
      end else if ((i > 0) && (i < NREGS) && !w_same_rd) begin
        if (w_inc && (issue_rd == 5'(i))) begin
          w_cnt_next[i] = w_cnt[i] + CNT_ONE;
        end else if (w_wb && (wb_rd == 5'(i)) && (w_cnt[i] != '0)) begin
          w_cnt_next[i] = w_cnt[i] - CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    w_sum = 7'd0;
    for (int i = 0; i < 32; i++) begin
      w_sum = w_sum + 7'(w_cnt_next[i]);
    end
  end

  genvar gi;
  for (gi = 0; gi < 32; gi++) begin : g_reg
    if ((gi > 0) && (gi < NREGS)) begin : g_cnt
      logic [CNTW-1:0] r_cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= w_cnt_next[gi];
        end
      end
      assign w_cnt[gi] = r_cnt;
    end else begin : g_zero
      assign w_cnt[gi] = '0;
    end
    assign busy_mask[gi] = (w_cnt[gi] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= 7'd0;
      r_err         <= 1'b0;
    end else begin
      r_outstanding <= w_sum;
      r_err         <= r_err | w_underflow;
    end
  end

  assign outstanding   = r_outstanding;
  assign err_underflow = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios plus a randomized run, all
// checked against a counter-array reference model.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_uses_rs1, issue_uses_rs2, issue_RegWrite;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        issue_ready;
  logic [31:0] busy_mask;
  logic [6:0]  outstanding;
  logic        err_underflow;

  int tests_run = 0;
  int tests_failed = 0;

  int m_cnt [32];
  bit m_err;

  reg_scoreboard #(.NREGS(32), .CNTW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
    .issue_RegWrite(issue_RegWrite), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .issue_ready(issue_ready), .busy_mask(busy_mask),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit m_src_hazard(input bit uses, input int idx);
    if (!uses || idx == 0 || m_cnt[idx] == 0) return 1'b0;
    if (wb_valid && int'(wb_rd) == idx && m_cnt[idx] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_ready();
    bit sat;
    sat = issue_RegWrite && issue_rd != 0 && m_cnt[issue_rd] == 3 &&
          !(wb_valid && wb_rd == issue_rd);
    return !flush && !m_src_hazard(issue_uses_rs1, int'(issue_rs1)) &&
           !m_src_hazard(issue_uses_rs2, int'(issue_rs2)) && !sat;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
  endfunction

  function automatic void m_commit(input bit rdy);
    bit inc, wb;
    if (flush) begin
      m_clear();
      return;
    end
    inc = issue_valid && rdy && issue_RegWrite && issue_rd != 0;
    wb  = wb_valid && wb_rd != 0;
    if (wb && m_cnt[wb_rd] == 0) m_err = 1'b1;
    if (inc && wb && issue_rd == wb_rd) return;
    if (inc) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
    if (wb && m_cnt[wb_rd] > 0) m_cnt[wb_rd] = m_cnt[wb_rd] - 1;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  function automatic int m_sum();
    int s;
    s = 0;
    for (int i = 0; i < 32; i++) s += m_cnt[i];
    return s;
  endfunction

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_uses_rs1 = 0;
    issue_uses_rs2 = 0; issue_RegWrite = 0; issue_rd = 0;
    wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  // Present one cycle of inputs at the falling edge; settle 1 time unit.
  task automatic present(input bit v, input bit u1, input int rs1, input bit u2, input int rs2,
                         input bit rw, input int rd, input bit wv, input int wrd, input bit fl);
    @(negedge clk);
    issue_valid = v; issue_uses_rs1 = u1; issue_rs1 = 5'(rs1);
    issue_uses_rs2 = u2; issue_rs2 = 5'(rs2); issue_RegWrite = rw; issue_rd = 5'(rd);
    wb_valid = wv; wb_rd = 5'(wrd); flush = fl;
    #1;
  endtask

  task automatic tick();
    bit rdy;
    rdy = m_ready();
    @(posedge clk);
    m_commit(rdy);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    m_clear();
    m_err = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    m_clear();
    m_err = 0;
    #3;
    tests_run++;
    if (busy_mask !== 32'h0 || outstanding !== 7'd0 || err_underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%h out=%0d err=%b, want 0/0/0", busy_mask, outstanding, err_underflow);
    end
    tests_run++;
    if (issue_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready_noflush: got %b want 1", issue_ready);
    end
    flush = 1; #1;
    tests_run++;
    if (issue_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready_flush: got %b want 0", issue_ready);
    end
    flush = 0;
    @(negedge clk);
    rst_n = 1;
    $display("[TB] reset checked");
  endtask

  task automatic test_raw_hazard();
    present(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); tick();
    present(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (issue_ready !== 1'b0 || busy_mask !== 32'h20 || outstanding !== 7'd1) begin
      tests_failed++;
      $display("FAIL raw_hazard: ready=%b busy=%h out=%0d, want 0/00000020/1", issue_ready, busy_mask, outstanding);
    end
    $display("[TB] raw hazard rd=5: ready=%b busy=%h out=%0d", issue_ready, busy_mask, outstanding);
  endtask

  task automatic test_wb_bypass();
    present(1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
    tests_run++;
    if (issue_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL wb_bypass_ready: got %b want 1", issue_ready);
    end
    tick();
    tests_run++;
    if (busy_mask !== 32'h0 || outstanding !== 7'd0) begin
      tests_failed++;
      $display("FAIL wb_bypass_after: busy=%h out=%0d want 0/0", busy_mask, outstanding);
    end
    $display("[TB] wb bypass x5: busy=%h out=%0d", busy_mask, outstanding);
  endtask

  task automatic test_saturation();
    repeat (3) begin present(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); tick(); end
    present(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    tests_run++;
    if (issue_ready !== 1'b0 || outstanding !== 7'd3) begin
      tests_failed++;
      $display("FAIL saturation_stall: ready=%b out=%0d want 0/3", issue_ready, outstanding);
    end
    tick();
    tests_run++;
    if (outstanding !== 7'd3) begin
      tests_failed++;
      $display("FAIL saturation_hold: out=%0d want 3", outstanding);
    end
    present(1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
    tests_run++;
    if (issue_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL saturation_wb_ready: got %b want 1", issue_ready);
    end
    tick();
    tests_run++;
    if (outstanding !== 7'd3 || busy_mask !== 32'h80) begin
      tests_failed++;
      $display("FAIL saturation_net_zero: out=%0d busy=%h want 3/00000080", outstanding, busy_mask);
    end
    $display("[TB] saturation x7: out=%0d", outstanding);
    do_reset();
  endtask

  task automatic test_x0();
    repeat (4) begin
      present(1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
      tests_run++;
      if (issue_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL x0_ready: got %b want 1", issue_ready);
      end
      tick();
    end
    present(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    tests_run++;
    if (busy_mask !== 32'h0 || outstanding !== 7'd0 || err_underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL x0_state: busy=%h out=%0d err=%b want 0/0/0", busy_mask, outstanding, err_underflow);
    end
    $display("[TB] x0 writes ignored: busy=%h err=%b", busy_mask, err_underflow);
  endtask

  task automatic test_flush();
    present(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); tick();
    present(1, 0, 0, 0, 0, 1, 9, 0, 0, 0); tick();
    present(1, 0, 0, 0, 0, 1, 9, 0, 0, 0); tick();
    tests_run++;
    if (busy_mask !== 32'h208 || outstanding !== 7'd3) begin
      tests_failed++;
      $display("FAIL flush_pre: busy=%h out=%0d want 00000208/3", busy_mask, outstanding);
    end
    present(1, 0, 0, 0, 0, 1, 4, 1, 3, 1);
    tests_run++;
    if (issue_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_ready: got %b want 0", issue_ready);
    end
    tick();
    tests_run++;
    if (busy_mask !== 32'h0 || outstanding !== 7'd0 || err_underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_after: busy=%h out=%0d err=%b want 0/0/0", busy_mask, outstanding, err_underflow);
    end
    present(0, 0, 0, 0, 0, 0, 0, 1, 9, 1); tick();
    tests_run++;
    if (err_underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_no_underflow: err=%b want 0", err_underflow);
    end
    $display("[TB] flush: busy=%h out=%0d", busy_mask, outstanding);
  endtask

  task automatic test_underflow();
    present(0, 0, 0, 0, 0, 0, 0, 1, 12, 0); tick();
    tests_run++;
    if (err_underflow !== 1'b1 || outstanding !== 7'd0) begin
      tests_failed++;
      $display("FAIL underflow_set: err=%b out=%0d want 1/0", err_underflow, outstanding);
    end
    present(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    tests_run++;
    if (err_underflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL underflow_sticky_flush: err=%b want 1", err_underflow);
    end
    present(1, 0, 0, 0, 0, 1, 6, 0, 0, 0); tick();
    @(negedge clk);
    idle_inputs();
    #2 rst_n = 0;
    m_clear();
    m_err = 0;
    #1;
    tests_run++;
    if (err_underflow !== 1'b0 || busy_mask !== 32'h0 || outstanding !== 7'd0) begin
      tests_failed++;
      $display("FAIL async_reset: err=%b busy=%h out=%0d want 0/0/0", err_underflow, busy_mask, outstanding);
    end
    @(negedge clk);
    rst_n = 1;
    $display("[TB] underflow sticky, cleared by async reset");
  endtask

  task automatic test_random();
    int errs;
    bit exp_rdy;
    errs = 0;
    for (int n = 0; n < 400; n++) begin
      present($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7),
              $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
              $urandom_range(0, 7), $urandom_range(0, 9) < 4, $urandom_range(0, 7),
              $urandom_range(0, 39) == 0);
      exp_rdy = m_ready();
      tests_run++;
      if (issue_ready !== exp_rdy) begin
        tests_failed++; errs++;
        $display("FAIL rand_ready[%0d]: got %b want %b", n, issue_ready, exp_rdy);
      end
      tick();
      tests_run++;
      if (busy_mask !== m_busy() || int'(outstanding) !== m_sum() || err_underflow !== m_err) begin
        tests_failed++; errs++;
        $display("FAIL rand_state[%0d]: busy=%h out=%0d err=%b want %h/%0d/%b",
                 n, busy_mask, outstanding, err_underflow, m_busy(), m_sum(), m_err);
      end
    end
    $display("[TB] random run: 400 cycles, %0d mismatching cycles", errs);
  endtask

  initial begin
    test_reset();
    test_raw_hazard();
    test_wb_bypass();
    test_saturation();
    test_x0();
    test_flush();
    test_underflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The module SHALL have parameter NREGS, default 32, giving the number of architectural integer registers tracked; x0 is included in the count.
REQ-002 The module SHALL have parameter CNTW, default 2, giving the width of each per-register pending-write counter, so the maximum count is 3.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 issue_valid  input  1  the decode stage presents an instruction.
REQ-006 issue_rs1, issue_rs2  input  5 each  source register indices.
REQ-007 issue_uses_rs1, issue_uses_rs2  input  1 each  the instruction reads that source.
REQ-008 issue_RegWrite  input  1  the instruction will write issue_rd.
REQ-009 issue_rd  input  5  destination register index.
REQ-010 wb_valid  input  1  the writeback stage retires a write this cycle, in the same cycle the register file samples RegWrite.
REQ-011 wb_rd  input  5  destination register index of the retiring write.
REQ-012 flush  input  1  synchronous pipeline flush.
REQ-013 issue_ready  output  1  the instruction may issue this cycle.
REQ-014 busy_mask  output  32  bit r is 1 while register r has at least one pending write.
REQ-015 outstanding  output  7  total pending writes summed over all registers.
REQ-016 err_underflow  output  1  sticky flag marking a writeback with no matching issue.

Function
REQ-017 The block SHALL hold a CNTW-bit counter cnt[r] for each r in 1..31; cnt[0] SHALL be a constant 0, and any index of 0 SHALL never raise a hazard or change a counter.
REQ-018 A source raw_hazard1 SHALL be raised when issue_uses_rs1 is 1, issue_rs1 != 0, and cnt[issue_rs1] != 0, unless the same-cycle writeback bypass applies.
REQ-019 The same-cycle writeback bypass SHALL apply when wb_valid is 1, wb_rd == issue_rs1, and cnt[issue_rs1] == 1; this matches the register file's write-to-read forwarding.
REQ-020 raw_hazard2 SHALL follow the same rule as raw_hazard1, using issue_uses_rs2 and issue_rs2.
REQ-021 A saturation stall SHALL be raised when issue_RegWrite is 1, issue_rd != 0, and cnt[issue_rd] == max, unless wb_valid is 1 and wb_rd == issue_rd in the same cycle.
REQ-022 issue_ready SHALL be combinational and equal to !flush && !raw_hazard1 && !raw_hazard2 && !saturation stall; issue_ready SHALL be independent of issue_valid.
REQ-023 An instruction SHALL be accepted when issue_valid && issue_ready is 1; on acceptance with issue_RegWrite=1 and issue_rd != 0, cnt[issue_rd] SHALL increment at the next edge.
REQ-024 On wb_valid=1 with wb_rd != 0 and cnt[wb_rd] > 0, cnt[wb_rd] SHALL decrement at the next edge.
REQ-025 On wb_valid=1 with wb_rd != 0 and cnt[wb_rd] == 0, the counter SHALL stay at 0 and err_underflow SHALL set at the next edge and stay set until reset.
REQ-026 When an accepted issue and a writeback target the same rd in one cycle, that counter SHALL stay unchanged (net 0).
REQ-027 When they target different registers, both updates SHALL apply in the same edge.
REQ-028 On flush=1, all counters SHALL clear to 0 at the next edge, and any issue or writeback in that cycle SHALL have no effect on the counters.
REQ-029 flush SHALL NOT clear err_underflow, and a writeback during flush SHALL NOT set it.
REQ-030 busy_mask SHALL be decoded from the registered counters with no same-cycle bypass, and busy_mask[0] SHALL always be 0.
REQ-031 outstanding SHALL be registered and equal to the sum of all cnt[r] after each edge, with a maximum of 93, so it never overflows 7 bits.
REQ-032 The block SHALL contain no other state and SHALL have 0-cycle combinational latency from the issue and wb inputs to issue_ready.

Reset
REQ-033 While rst_n=0, all counters, outstanding, and err_underflow SHALL be 0, busy_mask SHALL be 0, and issue_ready SHALL reflect only flush.
REQ-034 Reset asserted mid-operation SHALL discard all pending state immediately (asynchronously).
REQ-035 The first edge after rst_n rises SHALL process inputs normally.

Verification
REQ-036 Issue rd=5, then next cycle present uses_rs1=1, rs1=5 -> issue_ready=0, busy_mask=0x00000020, outstanding=1.
REQ-037 With cnt[5]=1, present wb_valid=1, wb_rd=5 and issue rs1=5 in the same cycle -> issue_ready=1, and after the edge cnt[5]=0 and busy_mask=0.
REQ-038 Issue rd=7 three times with no writeback, then a 4th issue rd=7 -> issue_ready=0 (saturation), outstanding=3; the 4th issue together with wb_rd=7 -> issue_ready=1 and cnt[7] stays 3.
REQ-039 Issue rd=0 with rs1=0 repeatedly -> issue_ready=1, busy_mask=0, outstanding=0; wb_rd=0 -> err_underflow stays 0.
REQ-040 With writes pending to x3, x9, and x9, assert flush together with issue rd=4 -> issue_ready=0, and after the edge busy_mask=0, outstanding=0, and x4 is not busy.
REQ-041 wb_valid=1 with wb_rd=12 while cnt[12]=0 -> err_underflow=1, held through a subsequent flush, and cleared only by rst_n=0.
